// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the single-clock FIFO.
package sync_fifo_pkg;

    localparam int SYNC_FIFO_DW = 8;
    localparam int SYNC_FIFO_AW = 5;

    // Number of storage words for a given address width.
    function automatic int sync_fifo_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port memory for sync_fifo: one write port, one registered read
// port, both on clk. The array itself is never reset; only the read register is.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DW = SYNC_FIFO_DW,
    parameter int AW = SYNC_FIFO_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = sync_fifo_depth(AW);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_reg;

    // Write port: store the word at the write address when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered output, cleared by reset, held when not reading.
    // The FIFO never reads and writes the same slot in one cycle, so no
    // read-during-write behaviour needs to be defined here.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Requests that would overflow or underflow are dropped.
// Optional occupancy output enabled by defining SYNC_FIFO_LEVEL_EN.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DW = SYNC_FIFO_DW,
    parameter int AW = SYNC_FIFO_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wen,
    input  logic [DW-1:0] wdata,
    output logic          wfull,
    input  logic          ren,
    output logic [DW-1:0] rdata,
    output logic          rempty
`ifdef SYNC_FIFO_LEVEL_EN
    ,
    output logic [AW:0]   level
`endif
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wptr_reg;
    logic [AW:0] wptr_next;
    logic [AW:0] rptr_reg;
    logic [AW:0] rptr_next;
    logic        wr_accept;
    logic        rd_accept;

    assign rempty = (wptr_reg == rptr_reg);
    assign wfull  = (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]) &&
                    (wptr_reg[AW] != rptr_reg[AW]);

    // Flags are evaluated before this cycle's operations, so a full FIFO
    // drops a simultaneous write and an empty FIFO ignores a simultaneous read.
    assign wr_accept = wen && !wfull;
    assign rd_accept = ren && !rempty;

    // Next-pointer logic: advance each pointer on its accepted operation.
    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        if (wr_accept) begin
            wptr_next = wptr_reg + PTR_ONE;
        end
        if (rd_accept) begin
            rptr_next = rptr_reg + PTR_ONE;
        end
    end

    // Pointer registers; reset discards contents by realigning both pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
        end
    end

`ifdef SYNC_FIFO_LEVEL_EN
    // Modular difference of the pointers gives 0..2**AW directly.
    assign level = wptr_reg - rptr_reg;
`endif

    sync_fifo_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_accept),
        .waddr (wptr_reg[AW-1:0]),
        .wdata (wdata),
        .re    (rd_accept),
        .raddr (rptr_reg[AW-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (default DW=8, AW=5).
// Level checks are active when SYNC_FIFO_LEVEL_EN is defined.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk;
    logic          rst;
    logic          wen;
    logic [DW-1:0] wdata;
    logic          wfull;
    logic          ren;
    logic [DW-1:0] rdata;
    logic          rempty;
`ifdef SYNC_FIFO_LEVEL_EN
    logic [AW:0]   level;
`endif

    sync_fifo #(
        .DW (DW),
        .AW (AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wen    (wen),
        .wdata  (wdata),
        .wfull  (wfull),
        .ren    (ren),
        .rdata  (rdata),
        .rempty (rempty)
`ifdef SYNC_FIFO_LEVEL_EN
        ,
        .level  (level)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run;
    int tests_failed;

    // Reference model: stored words, plus scoreboard of expected read data.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_rdata;

    typedef struct {
        logic          wen;
        logic [DW-1:0] wdata;
        logic          ren;
        logic [DW-1:0] exp_rdata;
        logic          exp_empty;
        logic          exp_full;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare flags (and level) against the model's occupancy.
    task automatic check_flags(input string tag);
        check({tag, " rempty"}, 32'(rempty), 32'(model_q.size() == 0));
        check({tag, " wfull"},  32'(wfull),  32'(model_q.size() == DEPTH));
`ifdef SYNC_FIFO_LEVEL_EN
        check({tag, " level"},  32'(level),  32'(model_q.size()));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        wen = 1'b0;
        ren = 1'b0;
        wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        exp_q.delete();
        last_rdata = '0;
        check("reset rdata", 32'(rdata), 32'h0);
        check_flags("reset");
        $display("[TB] reset: rdata=%0h rempty=%0b wfull=%0b", rdata, rempty, wfull);
    endtask

    // One clock of stimulus with model update and scoreboard comparison.
    task automatic step(input logic w, input logic [DW-1:0] wd, input logic r);
        logic w_ok;
        logic r_ok;
        @(negedge clk);
        wen   = w;
        wdata = wd;
        ren   = r;
        w_ok  = w && (model_q.size() < DEPTH);
        r_ok  = r && (model_q.size() > 0);
        if (r_ok) exp_q.push_back(model_q.pop_front());
        if (w_ok) model_q.push_back(wd);
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
        if (exp_q.size() > 0) begin
            last_rdata = exp_q.pop_front();
            check("read data", 32'(rdata), 32'(last_rdata));
        end else begin
            check("rdata hold", 32'(rdata), 32'(last_rdata));
        end
        check_flags("step");
        $display("[TB] wen=%0b wdata=%0h ren=%0b -> rdata=%0h rempty=%0b wfull=%0b",
                 w, wd, r, rdata, rempty, wfull);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        wen   = 1'b0;
        ren   = 1'b0;
        wdata = '0;
        last_rdata = '0;

        // Hand-derived vectors starting from an empty FIFO with rdata=0.
        vecs[0] = '{1'b1, 8'hA1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'hB2, 1'b1, 8'hA1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 8'hB2, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 8'hB2, 1'b1, 1'b0};  // underflow ignored
        vecs[4] = '{1'b1, 8'hC3, 1'b1, 8'hB2, 1'b0, 1'b0};  // empty: write only
        vecs[5] = '{1'b0, 8'h00, 1'b1, 8'hC3, 1'b1, 1'b0};

        do_reset();

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wen   = vecs[i].wen;
            wdata = vecs[i].wdata;
            ren   = vecs[i].ren;
            @(posedge clk);
            #1;
            wen = 1'b0;
            ren = 1'b0;
            check($sformatf("vec%0d rdata", i),  32'(rdata),  32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d rempty", i), 32'(rempty), 32'(vecs[i].exp_empty));
            check($sformatf("vec%0d wfull", i),  32'(wfull),  32'(vecs[i].exp_full));
            $display("[TB] vec%0d wen=%0b wdata=%0h ren=%0b -> rdata=%0h rempty=%0b wfull=%0b",
                     i, vecs[i].wen, vecs[i].wdata, vecs[i].ren, rdata, rempty, wfull);
        end

        // Fill to full, then an overflowing write is dropped.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
        check("full after 32", 32'(wfull), 32'h1);
        step(1'b1, 8'd32, 1'b0);

        // Drain in order; extra read leaves rdata at 31.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
        check("empty after drain", 32'(rempty), 32'h1);
        step(1'b0, 8'h00, 1'b1);
        check("rdata after underflow", 32'(rdata), 32'd31);

        // Streaming across pointer wrap, reader one cycle behind.
        step(1'b1, 8'd32, 1'b0);
        for (int i = 33; i < 72; i++) step(1'b1, 8'(i), 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("stream last", 32'(rdata), 32'd71);

        // Simultaneous read and write while full: read wins, 99 dropped.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'd99, 1'b1);
        check("full rw rdata", 32'(rdata), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1);
        check("full rw drained", 32'(rdata), 32'd31);

        // Mid-operation reset with 10 words stored.
        for (int i = 0; i < 10; i++) step(1'b1, 8'(100 + i), 1'b0);
        do_reset();
        step(1'b1, 8'd5, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("post reset read", 32'(rdata), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
